// File: rtl/noc_input_port.sv
// -----------------------------------------------------------------------------
// noc_input_port
//
// Input port of a 2-D mesh router. Flits arriving from the link are buffered
// in a small FIFO. A two-state FSM looks at the FIFO head:
//   IDLE   - a head flit (type 10 or 11) has its XY route computed and
//            registered into sel_o, then the FSM moves to ACTIVE. A stray
//            body/tail flit (type 00 or 01) is popped, dropped, and flagged
//            on err_o.
//   ACTIVE - flits stream to the crossbar demux with the route held constant
//            (wormhole). Popping a tail (01) or single-flit packet (11)
//            returns the FSM to IDLE.
//
// Flit format: [15:14] type (10 head, 00 body, 01 tail, 11 head+tail)
//              head only: [13:11] dest_x, [10:8] dest_y, [7:0] payload
//
// Handshakes (both sides): a transfer happens on a rising clock edge where
// valid and ready are both 1. valid may not depend on ready. The link side
// pushes on valid_i & ready_o; the crossbar side pops on valid_o & ready_i.
//
// Parameters
//   DEPTH     FIFO entries, power of two, >= 2
//   ROUTER_X  this router's X coordinate (3 bits used)
//   ROUTER_Y  this router's Y coordinate (3 bits used)
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   data_i       incoming flit
//   valid_i      data_i valid
//   ready_o      FIFO not full
//   data_o       FIFO head flit (unspecified when empty)
//   sel_o        demux select: 000 N, 001 S, 010 W, 011 E, 100 L
//   valid_o      data_o / sel_o valid (only in ACTIVE with a non-empty FIFO)
//   ready_i      downstream accepts the flit this cycle
//   err_o        one-cycle pulse when a stray flit is dropped
//   err_cnt_o    (only with INPORT_ERR_CNT_EN) saturating 8-bit drop counter
//   dbg_state_o  FSM state for observation: 0 IDLE, 1 ACTIVE
//
// Optional feature macro: INPORT_ERR_CNT_EN adds err_cnt_o and its counter.
// -----------------------------------------------------------------------------
module noc_input_port #(
    parameter int DEPTH    = 4,
    parameter int ROUTER_X = 0,
    parameter int ROUTER_Y = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] data_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic [15:0] data_o,
    output logic [2:0]  sel_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        err_o,
`ifdef INPORT_ERR_CNT_EN
    output logic [7:0]  err_cnt_o,
`endif
    output logic        dbg_state_o
);

    // -------------------------------------------------------------------------
    // Local constants
    // -------------------------------------------------------------------------
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

    localparam logic [2:0] ROUTER_X3 = ROUTER_X[2:0];
    localparam logic [2:0] ROUTER_Y3 = ROUTER_Y[2:0];

    localparam logic [2:0] SEL_N = 3'b000;
    localparam logic [2:0] SEL_S = 3'b001;
    localparam logic [2:0] SEL_W = 3'b010;
    localparam logic [2:0] SEL_E = 3'b011;
    localparam logic [2:0] SEL_L = 3'b100;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Storage and state
    // -------------------------------------------------------------------------
    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    state_t        state;

    logic          full;
    logic          empty;
    logic [15:0]   head;
    logic [1:0]    head_type;
    logic          push;
    logic          deliver;
    logic          drop;
    logic          pop;

    // -------------------------------------------------------------------------
    // XY dimension-order routing: resolve X first, then Y, else local.
    // -------------------------------------------------------------------------
    function automatic logic [2:0] xy_route(input logic [2:0] dest_x,
                                            input logic [2:0] dest_y);
        logic [2:0] sel;
        if (dest_x > ROUTER_X3) begin
            sel = SEL_E;
        end else if (dest_x < ROUTER_X3) begin
            sel = SEL_W;
        end else if (dest_y > ROUTER_Y3) begin
            sel = SEL_N;
        end else if (dest_y < ROUTER_Y3) begin
            sel = SEL_S;
        end else begin
            sel = SEL_L;
        end
        return sel;
    endfunction

    // -------------------------------------------------------------------------
    // FIFO status and handshake decode
    // -------------------------------------------------------------------------
    assign full      = (count == COUNT_FULL);
    assign empty     = (count == '0);
    assign head      = mem[rd_ptr];
    assign head_type = head[15:14];

    assign ready_o   = ~full;
    assign data_o    = head;

    // valid_o is decoded from registered state and count only, so it never
    // depends on ready_i within the same cycle.
    assign valid_o   = (state == ACTIVE) & ~empty;

    assign push      = valid_i & ready_o;
    assign deliver   = valid_o & ready_i;

    // In IDLE the head must start a packet; anything else is a stray flit
    // left over from a broken packet and is discarded without waiting for
    // the downstream side.
    assign drop      = (state == IDLE) & ~empty & ~head_type[1];
    assign pop       = deliver | drop;

    assign dbg_state_o = (state == ACTIVE);

    // -------------------------------------------------------------------------
    // FIFO storage. Entries need no reset: they are only observable through
    // data_o, which is meaningless while the FIFO is empty.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= data_i;
        end
    end

    // -------------------------------------------------------------------------
    // FIFO pointers and occupancy. DEPTH is a power of two, so the pointers
    // wrap modulo DEPTH by natural overflow. full/empty come from count so
    // that the two conditions are never ambiguous.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Packet FSM with registered route and error pulse.
    // The route is captured one cycle after the head reaches the FIFO head,
    // which gives the two-cycle push-to-valid latency on an empty FIFO.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            sel_o <= SEL_N;
            err_o <= 1'b0;
        end else begin
            err_o <= drop;
            case (state)
                IDLE: begin
                    if (!empty && head_type[1]) begin
                        sel_o <= xy_route(head[13:11], head[10:8]);
                        state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    // type[0] set marks the last flit of a packet (01 or 11)
                    if (deliver && head_type[0]) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef INPORT_ERR_CNT_EN
    // -------------------------------------------------------------------------
    // Saturating stray-flit counter. It steps on the same edge that raises
    // err_o, so err_cnt_o already includes the drop being flagged.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_cnt_o <= 8'd0;
        end else if (drop && (err_cnt_o != 8'hFF)) begin
            err_cnt_o <= err_cnt_o + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_noc_input_port.sv
// -----------------------------------------------------------------------------
// Testbench for noc_input_port (DEPTH=4, ROUTER_X=1, ROUTER_Y=1).
//
// Two independent references are kept:
//   - a cycle model (queue of buffered flits, packet-open flag, route) that
//     predicts ready_o, valid_o, data_o, sel_o, err_o and the FSM state each
//     cycle;
//   - a stream parser that classifies every accepted flit at push time into
//     packet flits (queued with their route in exp_q) or strays, and checks
//     every delivered flit on the crossbar side against exp_q.
// Directed sequences cover the listed scenarios, followed by random packets.
// -----------------------------------------------------------------------------
module tb_noc_input_port;

    localparam int DEPTH = 4;
    localparam int RX    = 1;
    localparam int RY    = 1;

    // -------------------------------------------------------------------------
    // Clock / reset
    // -------------------------------------------------------------------------
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [15:0] data_i;
    logic        valid_i;
    logic        ready_o;
    logic [15:0] data_o;
    logic [2:0]  sel_o;
    logic        valid_o;
    logic        ready_i;
    logic        err_o;
    logic        dbg_state_o;
`ifdef INPORT_ERR_CNT_EN
    logic [7:0]  err_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    noc_input_port #(
        .DEPTH    (DEPTH),
        .ROUTER_X (RX),
        .ROUTER_Y (RY)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .data_i      (data_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .data_o      (data_o),
        .sel_o       (sel_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .err_o       (err_o),
`ifdef INPORT_ERR_CNT_EN
        .err_cnt_o   (err_cnt_o),
`endif
        .dbg_state_o (dbg_state_o)
    );

    // -------------------------------------------------------------------------
    // Counters and checking task
    // -------------------------------------------------------------------------
    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference state
    // -------------------------------------------------------------------------
    logic [15:0] m_q[$];        // flits held in the port
    bit          m_active;      // a packet is open on the crossbar side
    logic [2:0]  m_sel;         // route of the open/last packet
    bit          m_err;         // err pulse expected this cycle
    int          m_errcnt;

    logic [18:0] exp_q[$];      // scoreboard: {sel, flit} in delivery order
    bit          in_pkt;        // parser: inside a packet on the input stream
    logic [2:0]  pkt_sel;
    int          err_exp;       // strays identified by the parser
    int          err_seen;      // err_o pulses observed

    // XY routing from the coordinates, written as plain integer compares.
    function automatic logic [2:0] route_of(input logic [15:0] f);
        int dx;
        int dy;
        dx = int'(f[13:11]);
        dy = int'(f[10:8]);
        if (dx > RX)      return 3'b011;   // E
        else if (dx < RX) return 3'b010;   // W
        else if (dy > RY) return 3'b000;   // N
        else if (dy < RY) return 3'b001;   // S
        else              return 3'b100;   // L
    endfunction

    // Stream-level classification of an accepted flit.
    task automatic parse(input logic [15:0] f);
        if (!in_pkt) begin
            if (f[15]) begin
                pkt_sel = route_of(f);
                exp_q.push_back({pkt_sel, f});
                in_pkt = (f[15:14] == 2'b10);
            end else begin
                err_exp++;
            end
        end else begin
            exp_q.push_back({pkt_sel, f});
            if (f[15:14] == 2'b01 || f[15:14] == 2'b11) in_pkt = 0;
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        exp_q.delete();
        m_active = 0;
        m_sel    = 3'b000;
        m_err    = 0;
        m_errcnt = 0;
        in_pkt   = 0;
    endtask

    // -------------------------------------------------------------------------
    // One clock cycle. Called just after a falling edge with inputs already
    // driven; compares outputs, advances the model across the rising edge and
    // returns at the next falling edge. accepted reports a push this cycle.
    // -------------------------------------------------------------------------
    task automatic step(output bit accepted);
        bit          m_valid;
        bit          m_ready;
        bit          pop;
        bit          n_active;
        bit          n_err;
        logic [2:0]  n_sel;
        logic [18:0] e;

        m_valid = m_active && (m_q.size() > 0);
        m_ready = (m_q.size() < DEPTH);

        check("ready_o", ready_o, m_ready);
        check("valid_o", valid_o, m_valid);
        check("err_o", err_o, m_err);
        check("sel_o", sel_o, m_sel);
        check("state", dbg_state_o, m_active);
        if (m_valid) check("data_o", data_o, m_q[0]);
`ifdef INPORT_ERR_CNT_EN
        check("err_cnt_o", err_cnt_o, m_errcnt);
`endif

        if (err_o === 1'b1) err_seen++;

        // Crossbar-side scoreboard: every handshake must deliver the next
        // expected flit with its packet route.
        if (valid_o === 1'b1 && ready_i === 1'b1) begin
            check("sb_nonempty", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_flit", {sel_o, data_o}, e);
            end
        end

        n_active = m_active;
        n_sel    = m_sel;
        n_err    = 0;
        pop      = 0;
        if (!m_active && m_q.size() > 0) begin
            if (m_q[0][15]) begin
                n_active = 1;
                n_sel    = route_of(m_q[0]);
            end else begin
                pop   = 1;
                n_err = 1;
            end
        end
        if (m_valid && ready_i) begin
            pop = 1;
            if (m_q[0][14]) n_active = 0;
        end

        accepted = valid_i && m_ready;
        if (accepted) parse(data_i);

        @(posedge clk_i);
        if (pop) void'(m_q.pop_front());
        if (accepted) m_q.push_back(data_i);
        m_active = n_active;
        m_sel    = n_sel;
        m_err    = n_err;
        if (n_err && m_errcnt < 255) m_errcnt++;
        @(negedge clk_i);
    endtask

    task automatic idle_cycles(input int n);
        bit acc;
        valid_i = 1'b0;
        for (int i = 0; i < n; i++) step(acc);
    endtask

    // Offer one flit until accepted, with a bounded wait.
    task automatic send_flit(input logic [15:0] f, input bit rand_rdy);
        bit acc;
        acc = 0;
        valid_i = 1'b1;
        data_i  = f;
        for (int i = 0; i < 200 && !acc; i++) begin
            if (rand_rdy) ready_i = ($urandom_range(0, 3) != 0);
            step(acc);
        end
        check("send_accept", acc, 1);
        valid_i = 1'b0;
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must clear at once.
    task automatic do_reset();
        #2 rst_i = 1'b1;
        #1;
        check("rst_valid_o", valid_o, 0);
        check("rst_sel_o", sel_o, 0);
        check("rst_err_o", err_o, 0);
        check("rst_state", dbg_state_o, 0);
        check("rst_ready_o", ready_o, 1);
        model_clear();
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    // Watchdog
    // -------------------------------------------------------------------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        bit acc;
        int snap;
        logic [15:0] f;
        int kind;
        int nbody;

        rst_i   = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        data_i  = 16'h0000;
        err_exp  = 0;
        err_seen = 0;
        model_clear();

        repeat (2) @(negedge clk_i);
        check("reset_valid_o", valid_o, 0);
        check("reset_sel_o", sel_o, 0);
        check("reset_err_o", err_o, 0);
        check("reset_state", dbg_state_o, 0);
        rst_i = 1'b0;
        check("first_ready_o", ready_o, 1);

        // Single-flit packet heading east, two-cycle latency.
        ready_i = 1'b1;
        send_flit(16'hE1AB, 0);
        check("e1ab_lat1_valid", valid_o, 0);
        step(acc);
        check("e1ab_valid", valid_o, 1);
        check("e1ab_sel", sel_o, 3'b011);
        check("e1ab_data", data_o, 16'hE1AB);
        step(acc);
        check("e1ab_idle", dbg_state_o, 0);
        check("e1ab_valid_after", valid_o, 0);

        // Three-flit packet to the local port, consecutive pops.
        send_flit(16'h8955, 0);
        send_flit(16'h0012, 0);
        send_flit(16'h4034, 0);
        idle_cycles(5);
        check("local_pkt_idle", dbg_state_o, 0);
        check("local_pkt_drained", exp_q.size(), 0);

        // Fill the FIFO with the consumer stalled.
        ready_i = 1'b0;
        send_flit(16'h8955, 0);
        send_flit(16'h0011, 0);
        send_flit(16'h0022, 0);
        send_flit(16'h0033, 0);
        check("full_ready_o", ready_o, 0);
        valid_i = 1'b1;
        data_i  = 16'h4044;
        step(acc);
        check("full_reject", acc, 0);
        ready_i = 1'b1;
        send_flit(16'h4044, 0);
        idle_cycles(6);
        check("full_pkt_drained", exp_q.size(), 0);

        // Stray body flit in IDLE is dropped with one err pulse.
        snap = err_seen;
        send_flit(16'h1234, 0);
        idle_cycles(3);
        check("stray_err_once", err_seen - snap, 1);
`ifdef INPORT_ERR_CNT_EN
        check("stray_err_cnt", err_cnt_o, 1);
`endif

        // Reset in the middle of a packet, then a fresh head.
        ready_i = 1'b0;
        send_flit(16'h8955, 0);
        send_flit(16'h0012, 0);
        step(acc);
        do_reset();
        snap = err_seen;
        ready_i = 1'b1;
        send_flit(16'hC9FF, 0);
        step(acc);
        check("post_rst_valid", valid_o, 1);
        check("post_rst_sel", sel_o, 3'b100);
        idle_cycles(3);
        check("post_rst_no_err", err_seen - snap, 0);

        // Three-flit packet drained with ready_i toggling.
        ready_i = 1'b0;
        send_flit(16'h8955, 0);
        send_flit(16'h0012, 0);
        send_flit(16'h4034, 0);
        for (int i = 0; i < 8; i++) begin
            ready_i = (i % 2 == 0);
            step(acc);
        end
        check("toggle_drained", exp_q.size(), 0);

        // Random packets: heads with random destinations, bodies, tails,
        // single-flit packets and occasional strays, with random backpressure.
        for (int p = 0; p < 80; p++) begin
            kind = $urandom_range(0, 9);
            f = 16'($urandom_range(0, 16'h3FFF));
            if (kind == 0) begin
                f[15:14] = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b00;
                send_flit(f, 1);
            end else if (kind <= 2) begin
                f[15:14] = 2'b11;
                send_flit(f, 1);
            end else begin
                f[15:14] = 2'b10;
                send_flit(f, 1);
                nbody = $urandom_range(0, 3);
                for (int b = 0; b < nbody; b++) begin
                    f = 16'($urandom_range(0, 16'h3FFF));
                    send_flit(f, 1);
                end
                f = 16'($urandom_range(0, 16'h3FFF));
                f[15:14] = 2'b01;
                send_flit(f, 1);
            end
            if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 2));
        end

        // Drain and final accounting.
        ready_i = 1'b1;
        idle_cycles(12);
        check("final_drained", exp_q.size(), 0);
        check("final_valid_o", valid_o, 0);
        check("final_err_total", err_seen, err_exp);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
